// File: rtl/deco_anillo_pkg.sv
// Shared constants for the four-digit ring scan decoder.
package deco_anillo_pkg;
  localparam int               NUM_DIGITS  = 4;
  localparam int               SEL_W       = 2;
  localparam logic [NUM_DIGITS-1:0] ANODE_RESET = 4'b0111;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF   = 4'b1111;
endpackage

// File: rtl/deco_anillo_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 and pulses i_Tick for one cycle at DIV-1.
// With DIV=1 the count never leaves 0, so the tick is permanently high.
module deco_anillo_prescaler #(
  parameter int DIV = 1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  output logic o_Tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DIV - 1));
  assign o_Tick = w_last;

  // Free-running modulo-DIV counter, cleared by reset and after the last count.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)     r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/deco_anillo.sv
// Four-digit ring-counter anode scanner for a common-anode 7-segment display.
// Optional macro DECO_ANILLO_BLANK_EN adds i_Blank, which forces every anode
// off combinationally while the scan keeps running underneath.
module deco_anillo
  import deco_anillo_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
`ifdef DECO_ANILLO_BLANK_EN
  input  logic                  i_Blank,
`endif
  output logic [SEL_W-1:0]      o_Sel,
  output logic [NUM_DIGITS-1:0] o_Anodos
);
  logic                  w_tick;
  logic [NUM_DIGITS-1:0] r_ring;
  logic [SEL_W-1:0]      r_sel;

  deco_anillo_prescaler #(.DIV(DIV)) u_prescaler (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .o_Tick  (w_tick)
  );

  // Ring and index advance together on each tick so they can never disagree;
  // the ring rotates right (0111 -> 1011 -> ...) and sel wraps 3 -> 0 with it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_ring <= ANODE_RESET;
      r_sel  <= '0;
    end else if (w_tick) begin
      r_ring <= {r_ring[0], r_ring[NUM_DIGITS-1:1]};
      r_sel  <= r_sel + SEL_W'(1);
    end
  end

  assign o_Sel = r_sel;

`ifdef DECO_ANILLO_BLANK_EN
  assign o_Anodos = i_Blank ? ANODE_OFF : r_ring;
`else
  assign o_Anodos = r_ring;
`endif
endmodule

// File: tb/tb_deco_anillo.sv
// Directed bench for deco_anillo: one instance with DIV=1, one with DIV=4.
module tb_deco_anillo;
  logic       clk;
  logic       rst;
  logic       blank;
  logic [1:0] sel1, sel4;
  logic [3:0] an1, an4;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  deco_anillo #(.DIV(1)) dut1 (
    .i_Clk    (clk),
    .i_Reset  (rst),
`ifdef DECO_ANILLO_BLANK_EN
    .i_Blank  (blank),
`endif
    .o_Sel    (sel1),
    .o_Anodos (an1)
  );

  deco_anillo #(.DIV(4)) dut4 (
    .i_Clk    (clk),
    .i_Reset  (rst),
`ifdef DECO_ANILLO_BLANK_EN
    .i_Blank  (blank),
`endif
    .o_Sel    (sel4),
    .o_Anodos (an4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (sel1 !== 2'b00 || an1 !== 4'b0111) begin
        n_err++;
        $display("FAIL reset_div1 edge%0d: got sel=%b an=%b expected sel=00 an=0111", k, sel1, an1);
      end
      n_cmp++;
      if (sel4 !== 2'b00 || an4 !== 4'b0111) begin
        n_err++;
        $display("FAIL reset_div4 edge%0d: got sel=%b an=%b expected sel=00 an=0111", k, sel4, an4);
      end
    end
  endtask

  task automatic test_scan_div1();
    logic [3:0] exp_an  [8] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111,
                                4'b1011, 4'b1101, 4'b1110, 4'b0111};
    logic [1:0] exp_sel [8] = '{2'b01, 2'b10, 2'b11, 2'b00,
                                2'b01, 2'b10, 2'b11, 2'b00};
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (sel1 !== exp_sel[k] || an1 !== exp_an[k]) begin
        n_err++;
        $display("FAIL scan_div1 edge%0d: got sel=%b an=%b expected sel=%b an=%b",
                 k + 1, sel1, an1, exp_sel[k], exp_an[k]);
      end
    end
  endtask

  task automatic test_scan_div4();
    logic [1:0] es;
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      es = 2'((k / 4) % 4);
      n_cmp++;
      if (sel4 !== es || an4 !== an_tab[es]) begin
        n_err++;
        $display("FAIL scan_div4 edge%0d: got sel=%b an=%b expected sel=%b an=%b",
                 k, sel4, an4, es, an_tab[es]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] es;
    // DIV=1: reach sel=10 after two edges, then reset for one clock.
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    n_cmp++;
    if (sel1 !== 2'b10 || an1 !== 4'b1101) begin
      n_err++;
      $display("FAIL midrst_div1_pre: got sel=%b an=%b expected sel=10 an=1101", sel1, an1);
    end
    rst = 1'b1; step();
    n_cmp++;
    if (sel1 !== 2'b00 || an1 !== 4'b0111) begin
      n_err++;
      $display("FAIL midrst_div1_rst: got sel=%b an=%b expected sel=00 an=0111", sel1, an1);
    end
    rst = 1'b0; step();
    n_cmp++;
    if (sel1 !== 2'b01 || an1 !== 4'b1011) begin
      n_err++;
      $display("FAIL midrst_div1_post: got sel=%b an=%b expected sel=01 an=1011", sel1, an1);
    end
    // DIV=4: 10 edges puts sel=10 with the prescaler at 2; reset must clear both.
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (sel4 !== 2'b10 || an4 !== 4'b1101) begin
      n_err++;
      $display("FAIL midrst_div4_pre: got sel=%b an=%b expected sel=10 an=1101", sel4, an4);
    end
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      es = (k == 4) ? 2'b01 : 2'b00;
      n_cmp++;
      if (sel4 !== es || an4 !== an_tab[es]) begin
        n_err++;
        $display("FAIL midrst_div4_post edge%0d: got sel=%b an=%b expected sel=%b an=%b",
                 k, sel4, an4, es, an_tab[es]);
      end
    end
  endtask

  task automatic test_invariant();
    int bad = 0;
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if ($countones(~an1) != 1 || an1 !== ~(4'b1000 >> sel1)) bad++;
      if ($countones(~an4) != 1 || an4 !== ~(4'b1000 >> sel4)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL invariant: got %0d bad cycles expected 0", bad);
    end
  endtask

`ifdef DECO_ANILLO_BLANK_EN
  task automatic test_blank();
    logic [1:0] exp_sel [3] = '{2'b10, 2'b11, 2'b00};
    rst = 1'b1; step();
    rst = 1'b0; step();
    blank = 1'b1;
    #1;
    n_cmp++;
    if (sel1 !== 2'b01 || an1 !== 4'b1111) begin
      n_err++;
      $display("FAIL blank_on: got sel=%b an=%b expected sel=01 an=1111", sel1, an1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (sel1 !== exp_sel[k] || an1 !== 4'b1111) begin
        n_err++;
        $display("FAIL blank_hold edge%0d: got sel=%b an=%b expected sel=%b an=1111",
                 k, sel1, an1, exp_sel[k]);
      end
    end
    blank = 1'b0;
    #1;
    n_cmp++;
    if (sel1 !== 2'b00 || an1 !== 4'b0111) begin
      n_err++;
      $display("FAIL blank_off: got sel=%b an=%b expected sel=00 an=0111", sel1, an1);
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    blank = 1'b0;
    test_reset();
    test_scan_div1();
    test_scan_div4();
    test_mid_reset();
    test_invariant();
`ifdef DECO_ANILLO_BLANK_EN
    test_blank();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
